// File: rtl/rop_csr_unit.sv
// rop_csr_unit: CSR endpoint for the ROP blend/logic-op render state.
// Accepts CSR writes/reads from the command path and drives the packed
// rop_csrs_t state consumed by the ROP datapath.
// Build option: define ROP_CSR_SHADOW_EN to stage writes in a shadow copy that
// is transferred to the active copy by a COMMIT write once the ROP is idle.
// Without it a single register set drives rop_csrs directly.

package rop_csr_pkg;
  localparam int ROP_BLEND_FACTOR_BITS = 4;
  localparam int ROP_LOGIC_OP_BITS     = 4;

  typedef struct packed {
    logic [ROP_BLEND_FACTOR_BITS-1:0] blend_src_rgb;
    logic [ROP_BLEND_FACTOR_BITS-1:0] blend_dst_rgb;
    logic [ROP_BLEND_FACTOR_BITS-1:0] blend_src_a;
    logic [ROP_BLEND_FACTOR_BITS-1:0] blend_dst_a;
    logic [31:0]                      blend_const;
    logic [ROP_LOGIC_OP_BITS-1:0]     logic_op;
  } rop_csrs_t;
endpackage

module rop_csr_unit
  import rop_csr_pkg::*;
#(
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 rd_req_valid,
  output logic                 rd_req_ready,
  input  logic [ADDR_BITS-1:0] rd_req_addr,
  output logic                 rd_rsp_valid,
  input  logic                 rd_rsp_ready,
  output logic [31:0]          rd_rsp_data,
  input  logic                 rop_idle,
  output rop_csrs_t            rop_csrs,
  output logic                 commit_done,
  output logic                 busy
);

  localparam int F = ROP_BLEND_FACTOR_BITS;
  localparam int L = ROP_LOGIC_OP_BITS;

  localparam logic [ADDR_BITS-1:0] A_BLEND_RGB   = ADDR_BITS'(0);
  localparam logic [ADDR_BITS-1:0] A_BLEND_A     = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] A_BLEND_CONST = ADDR_BITS'(2);
  localparam logic [ADDR_BITS-1:0] A_LOGIC_OP    = ADDR_BITS'(3);
  localparam logic [ADDR_BITS-1:0] A_COMMIT      = ADDR_BITS'(4);

  // Blend factors reset to ONE (src) / ZERO (dst): plain pass-through of the source.
  localparam rop_csrs_t CSRS_RST = '{
    blend_src_rgb: F'(1), blend_dst_rgb: '0,
    blend_src_a:   F'(1), blend_dst_a:   '0,
    blend_const:   '0,    logic_op:      '0
  };

  // Applies one CSR write to a register set; COMMIT and unmapped offsets leave it unchanged.
  function automatic rop_csrs_t csr_write(input rop_csrs_t cur,
                                          input logic [ADDR_BITS-1:0] addr,
                                          input logic [31:0] data);
    rop_csrs_t nxt;
    nxt = cur;
    case (addr)
      A_BLEND_RGB: begin
        nxt.blend_src_rgb = data[F-1:0];
        nxt.blend_dst_rgb = data[16+F-1:16];
      end
      A_BLEND_A: begin
        nxt.blend_src_a = data[F-1:0];
        nxt.blend_dst_a = data[16+F-1:16];
      end
      A_BLEND_CONST: nxt.blend_const = data;
      A_LOGIC_OP:    nxt.logic_op    = data[L-1:0];
      default:       nxt = cur;
    endcase
    return nxt;
  endfunction

  // Packs a register set back into bus format; unmapped bits and offsets read as zero.
  function automatic logic [31:0] csr_read(input rop_csrs_t s,
                                           input logic [ADDR_BITS-1:0] addr);
    logic [31:0] r;
    r = '0;
    case (addr)
      A_BLEND_RGB: begin
        r[F-1:0]     = s.blend_src_rgb;
        r[16+F-1:16] = s.blend_dst_rgb;
      end
      A_BLEND_A: begin
        r[F-1:0]     = s.blend_src_a;
        r[16+F-1:16] = s.blend_dst_a;
      end
      A_BLEND_CONST: r = s.blend_const;
      A_LOGIC_OP:    r[L-1:0] = s.logic_op;
      default:       r = '0;
    endcase
    return r;
  endfunction

  logic        wr_fire;
  logic        rd_fire;
  logic        commit_done_q;
  logic        rd_rsp_valid_q;
  logic [31:0] rd_rsp_data_q;
  logic [31:0] rd_rsp_data_d;
  rop_csrs_t   read_src;

`ifdef ROP_CSR_SHADOW_EN
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t    state_q;
  logic      wr_ready_q;
  logic      busy_q;
  rop_csrs_t shadow_q;
  rop_csrs_t active_q;

  assign wr_fire  = wr_valid && wr_ready_q;
  assign wr_ready = wr_ready_q;
  assign busy     = busy_q;
  assign rop_csrs = active_q;
  assign read_src = shadow_q;

  // Commit FSM: stage writes in the shadow, copy to active on the first idle edge after COMMIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      wr_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      commit_done_q <= 1'b0;
      shadow_q      <= CSRS_RST;
      active_q      <= CSRS_RST;
    end else begin
      commit_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_fire) begin
            if (wr_addr == A_COMMIT) begin
              state_q    <= S_WAIT;
              wr_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              shadow_q <= csr_write(shadow_q, wr_addr, wr_data);
            end
          end
        end
        S_WAIT: begin
          if (rop_idle) begin
            active_q      <= shadow_q;
            commit_done_q <= 1'b1;
            state_q       <= S_IDLE;
            wr_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  rop_csrs_t regs_q;
  logic      unused_rop_idle;

  assign unused_rop_idle = rop_idle;
  assign wr_fire  = wr_valid;
  assign wr_ready = 1'b1;
  assign busy     = 1'b0;
  assign rop_csrs = regs_q;
  assign read_src = regs_q;

  // Single register set: writes land in the active state directly; COMMIT only pulses commit_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q        <= CSRS_RST;
      commit_done_q <= 1'b0;
    end else begin
      commit_done_q <= wr_fire && (wr_addr == A_COMMIT);
      if (wr_fire) begin
        regs_q <= csr_write(regs_q, wr_addr, wr_data);
      end
    end
  end
`endif

  assign commit_done   = commit_done_q;
  assign rd_req_ready  = !rd_rsp_valid_q || rd_rsp_ready;
  assign rd_fire       = rd_req_valid && rd_req_ready;
  assign rd_rsp_data_d = csr_read(read_src, rd_req_addr);
  assign rd_rsp_valid  = rd_rsp_valid_q;
  assign rd_rsp_data   = rd_rsp_data_q;

  // Read response register: sampled before this edge's write lands, held while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_rsp_valid_q <= 1'b0;
      rd_rsp_data_q  <= '0;
    end else if (rd_fire) begin
      rd_rsp_valid_q <= 1'b1;
      rd_rsp_data_q  <= rd_rsp_data_d;
    end else if (rd_rsp_ready) begin
      rd_rsp_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rop_csr_unit.sv
// Self-checking bench for rop_csr_unit; expectations follow ROP_CSR_SHADOW_EN.
module tb_rop_csr_unit;
  import rop_csr_pkg::*;

  localparam int F = ROP_BLEND_FACTOR_BITS;
  localparam int L = ROP_LOGIC_OP_BITS;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [2:0]  rd_req_addr;
  logic        rd_rsp_valid;
  logic        rd_rsp_ready;
  logic [31:0] rd_rsp_data;
  logic        rop_idle;
  rop_csrs_t   rop_csrs;
  logic        commit_done;
  logic        busy;

  always #5 clk = ~clk;

  rop_csr_unit #(.ADDR_BITS(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .rop_idle     (rop_idle),
    .rop_csrs     (rop_csrs),
    .commit_done  (commit_done),
    .busy         (busy)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] mreg[0:3];
  rop_csrs_t   rst_exp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mask_wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] fm;
    fm = (32'd1 << F) - 32'd1;
    case (a)
      3'd0, 3'd1: return d & (fm | (fm << 16));
      3'd2:       return d;
      3'd3:       return d & ((32'd1 << L) - 32'd1);
      default:    return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    mreg[0] = 32'd1;
    mreg[1] = 32'd1;
    mreg[2] = 32'd0;
    mreg[3] = 32'd0;
  endtask

  // Scoreboard: pop/compare responses, push expected data for accepted requests, then apply writes.
  always @(negedge clk) begin
    if (!reset_n) begin
      model_reset();
      sb.delete();
    end else begin
      if (rd_rsp_valid && rd_rsp_ready) begin
        if (sb.size() == 0) check_eq("rd_unexpected", 64'(sb.size()), 64'd1);
        else check_eq("rd_data", 64'(rd_rsp_data), 64'(sb.pop_front()));
      end
      if (rd_req_valid && rd_req_ready)
        sb.push_back(rd_req_addr < 3'd4 ? mreg[rd_req_addr[1:0]] : 32'd0);
      if (wr_valid && wr_ready && wr_addr < 3'd4)
        mreg[wr_addr[1:0]] = mask_wr(wr_addr, wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    int n;
    n        = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    while (!wr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) check_eq("wr_timeout", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a);
    rd_req_valid = 1'b1;
    rd_req_addr  = a;
    tick();
    rd_req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_rsp_ready = 1'b1; rop_idle = 1'b0;
    rst_exp = '0;
    rst_exp.blend_src_rgb = F'(1);
    rst_exp.blend_src_a   = F'(1);
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
    check_eq("rst_rsp_data",  64'(rd_rsp_data),  64'd0);
    check_eq("rst_commit",    64'(commit_done),  64'd0);
    check_eq("rst_busy",      64'(busy),         64'd0);
    check_eq("rst_wr_ready",  64'(wr_ready),     64'd1);
    check_eq("rst_rd_ready",  64'(rd_req_ready), 64'd1);
    check_eq("rst_csrs",      64'(rop_csrs),     64'(rst_exp));
    tick();
    reset_n = 1'b1;

    // Reset readback of all offsets, back to back
    for (int a = 0; a < 5; a++) do_read(3'(a));
    repeat (3) tick();
    check_eq("sb_drain_rst", 64'(sb.size()), 64'd0);

    // Shadow write to BLEND_RGB
    do_write(3'd0, 32'h0005_0004);
    do_read(3'd0);
    @(negedge clk);
`ifdef ROP_CSR_SHADOW_EN
    check_eq("src_rgb_pre_commit", 64'(rop_csrs.blend_src_rgb), 64'd1);
`else
    check_eq("src_rgb_direct", 64'(rop_csrs.blend_src_rgb), 64'd4);
`endif
    tick();

    // Blend constant then COMMIT while the ROP is busy
    do_write(3'd2, 32'hDEAD_BEEF);
    rop_idle = 1'b0;
    do_write(3'd4, 32'h0);
`ifdef ROP_CSR_SHADOW_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("wait_busy",     64'(busy),                 64'd1);
      check_eq("wait_wr_ready", 64'(wr_ready),             64'd0);
      check_eq("wait_const",    64'(rop_csrs.blend_const), 64'd0);
      check_eq("wait_commit",   64'(commit_done),          64'd0);
    end
    rop_idle = 1'b1;
    @(negedge clk);
    check_eq("commit_const",   64'(rop_csrs.blend_const),   64'hDEAD_BEEF);
    check_eq("commit_src_rgb", 64'(rop_csrs.blend_src_rgb), 64'd4);
    check_eq("commit_pulse",   64'(commit_done),            64'd1);
    check_eq("commit_busy",    64'(busy),                   64'd0);
    check_eq("commit_wr_rdy",  64'(wr_ready),               64'd1);
    rop_idle = 1'b0;
    @(negedge clk);
    check_eq("commit_pulse_end", 64'(commit_done), 64'd0);
    tick();
    // COMMIT accepted while already idle still spends one cycle in WAIT
    rop_idle = 1'b1;
    do_write(3'd1, 32'h0003_0002);
    do_write(3'd4, 32'h0);
    @(negedge clk);
    check_eq("min_wait_busy",  64'(busy),                 64'd1);
    check_eq("min_wait_src_a", 64'(rop_csrs.blend_src_a), 64'd1);
    check_eq("min_wait_pulse", 64'(commit_done),          64'd0);
    @(negedge clk);
    check_eq("min_src_a",  64'(rop_csrs.blend_src_a), 64'd2);
    check_eq("min_dst_a",  64'(rop_csrs.blend_dst_a), 64'd3);
    check_eq("min_pulse",  64'(commit_done),          64'd1);
    rop_idle = 1'b0;
    tick();
`else
    @(negedge clk);
    check_eq("commit_pulse",  64'(commit_done),          64'd1);
    check_eq("commit_busy",   64'(busy),                 64'd0);
    check_eq("commit_wr_rdy", 64'(wr_ready),             64'd1);
    check_eq("commit_const",  64'(rop_csrs.blend_const), 64'hDEAD_BEEF);
    @(negedge clk);
    check_eq("commit_pulse_end", 64'(commit_done), 64'd0);
    tick();
    do_write(3'd1, 32'h0003_0002);
    @(negedge clk);
    check_eq("direct_src_a", 64'(rop_csrs.blend_src_a), 64'd2);
    tick();
`endif

    // Response back-pressure: request held while the response stalls
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_addr  = 3'd2;
    tick();
    rd_req_addr  = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_rd_ready",  64'(rd_req_ready), 64'd0);
      check_eq("stall_rsp_valid", 64'(rd_rsp_valid), 64'd1);
      check_eq("stall_rsp_data",  64'(rd_rsp_data),  64'hDEAD_BEEF);
      tick();
    end
    rd_rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("tput_0", 64'(rd_rsp_valid), 64'd1);
    tick();
    rd_req_addr = 3'd1;
    @(negedge clk);
    check_eq("tput_1", 64'(rd_rsp_valid), 64'd1);
    tick();
    rd_req_addr = 3'd3;
    @(negedge clk);
    check_eq("tput_2", 64'(rd_rsp_valid), 64'd1);
    tick();
    rd_req_valid = 1'b0;
    @(negedge clk);
    check_eq("tput_3", 64'(rd_rsp_valid), 64'd1);
    tick();
    repeat (2) tick();
    check_eq("sb_drain_stall", 64'(sb.size()), 64'd0);

    // Same-cycle read and write to LOGIC_OP: read sees the old value
    rd_req_valid = 1'b1; rd_req_addr = 3'd3;
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 32'h7;
    tick();
    rd_req_valid = 1'b0; wr_valid = 1'b0;
    do_read(3'd3);

    // Unmapped offsets: writes ignored, reads zero
    do_write(3'd6, 32'hFFFF_FFFF);
    do_read(3'd6);
    do_read(3'd4);
    do_read(3'd2);
    repeat (3) tick();
    check_eq("sb_drain_rw", 64'(sb.size()), 64'd0);

    // Reset asserted right after COMMIT acceptance aborts it
    rop_idle = 1'b0;
    do_write(3'd0, 32'h0009_0008);
    do_write(3'd4, 32'h0);
    reset_n = 1'b0;
    #1;
    check_eq("abort_busy",      64'(busy),         64'd0);
    check_eq("abort_wr_ready",  64'(wr_ready),     64'd1);
    check_eq("abort_commit",    64'(commit_done),  64'd0);
    check_eq("abort_rsp_valid", 64'(rd_rsp_valid), 64'd0);
    check_eq("abort_csrs",      64'(rop_csrs),     64'(rst_exp));
    rop_idle = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("abort_no_pulse", 64'(commit_done), 64'd0);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_no_pulse", 64'(commit_done), 64'd0);
      check_eq("post_busy",     64'(busy),        64'd0);
      check_eq("post_csrs",     64'(rop_csrs),    64'(rst_exp));
      tick();
    end
    rop_idle = 1'b0;
    do_read(3'd0);
    do_read(3'd3);
    repeat (3) tick();
    check_eq("sb_drain_end", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rop_csr_unit.md
# rop_csr_unit

Programming-side endpoint for the ROP render-state CSRs: it accepts CSR writes and reads from the command path, holds a shadow copy of the blend/logic-op state, and drives the packed `rop_csrs_t` state consumed by the ROP datapath. A commit handshake transfers shadow state to the active copy only while the ROP pipeline is idle, so in-flight fragments never see torn state. It sits between the core CSR bus and the ROP unit.

## Interface
- `ADDR_BITS`, 3: CSR offset width. Offsets 0–4 are mapped.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  CSR write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `wr_addr`  in  ADDR_BITS  write offset.
- `wr_data`  in  32  write data.
- `rd_req_valid`  in  1  CSR read request.
- `rd_req_ready`  out  1  read request accept.
- `rd_req_addr`  in  ADDR_BITS  read offset.
- `rd_rsp_valid`  out  1  read response valid.
- `rd_rsp_ready`  in  1  read response accept.
- `rd_rsp_data`  out  32  read data.
- `rop_idle`  in  1  ROP pipeline has no fragments in flight.
- `rop_csrs`  out  `rop_csrs_t`  active state (4·`ROP_BLEND_FACTOR_BITS` + 32 + `ROP_LOGIC_OP_BITS` bits).
- `commit_done`  out  1  one-cycle pulse when active state is updated.
- `busy`  out  1  commit pending.

## Operation
- F = `ROP_BLEND_FACTOR_BITS`, L = `ROP_LOGIC_OP_BITS`. Offset map:
  - 0 BLEND_RGB: src_rgb = data[F-1:0], dst_rgb = data[16+F-1:16].
  - 1 BLEND_A: src_a = data[F-1:0], dst_a = data[16+F-1:16].
  - 2 BLEND_CONST: data[31:0].
  - 3 LOGIC_OP: data[L-1:0].
  - 4 COMMIT: write-only, data ignored.
- Unmapped bits read as 0. Writes to offsets ≥5 are accepted and ignored. Reads of offsets 4 and ≥5 return 0.
- Reads return shadow values in the same packing.
- FSM:
  - IDLE: `wr_ready`=1. An accepted write to offset 0–3 updates the shadow at that edge. An accepted write to offset 4 moves to WAIT.
  - WAIT: `wr_ready`=0 and `busy`=1. On the first edge where `rop_idle`=1, active ← shadow, `commit_done`=1 for the following cycle, then IDLE.
  - If `rop_idle`=1 in the cycle the COMMIT write is accepted, the transfer still happens at the next edge (minimum 1 cycle in WAIT).
- Reads are serviced in every state.
- Reset values (shadow and active): src_rgb = src_a = 1 (ONE), dst_rgb = dst_a = 0 (ZERO), blend_const = 0, logic_op = 0.
- Output reset values: `rd_rsp_valid`=0, `rd_rsp_data`=0, `commit_done`=0, `busy`=0, `wr_ready`=1, `rd_req_ready`=1.
- Reset asserted mid-commit aborts the commit: FSM returns to IDLE with active = reset values.

## Timing
- Write: shadow visible to a read accepted one cycle after the write's acceptance.
- A read and a write to the same offset accepted in the same cycle: the read returns the old value.
- Read latency is 1 cycle, with a registered response.
- `rd_req_ready = !rd_rsp_valid || rd_rsp_ready`, giving full throughput with no bubbles when `rd_rsp_ready`=1.
- `rd_rsp_data` is held stable while `rd_rsp_valid && !rd_rsp_ready`.
- `rop_csrs` changes only on the commit edge and is registered (no combinational path from the write port).
- Commit latency, from COMMIT acceptance at edge T: active updates at the first edge ≥T+1 with `rop_idle`=1.

## Configuration
- `ROP_CSR_SHADOW_EN` defined: behaviour as above.
- `ROP_CSR_SHADOW_EN` undefined:
  - A single register set is used, so `rop_csrs` updates at the write-acceptance edge.
  - The COMMIT write is accepted and produces a `commit_done` pulse next cycle.
  - `busy`=0 and `wr_ready`=1 always; `rop_idle` is ignored.

## Test plan
- Reset, then read offsets 0–4 → 0x0000_0001, 0x0000_0001, 0x0, 0x0, 0x0. `rop_csrs` at reset values.
- Write 0x0005_0004 to offset 0 with F=4, then read offset 0 → 0x0005_0004. `rop_csrs.blend_src_rgb` stays 1 until commit.
- Write const 0xDEADBEEF and COMMIT with `rop_idle`=0 for 5 cycles → `busy`=1, `wr_ready`=0, active unchanged. Raise `rop_idle` → blend_const = 0xDEADBEEF at that edge, `commit_done` for one cycle, then `busy`=0.
- Back-to-back reads with `rd_rsp_ready` low for 3 cycles → `rd_req_ready`=0 and `rd_rsp_data` held. After release, one response per cycle in order.
- Same-cycle read and write to offset 3 with value 0x7 → read returns the prior value; the next read returns 0x7.
- Deassert `reset_n` during WAIT → outputs take reset values immediately, FSM is IDLE, and no `commit_done` pulse occurs.
